// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: program counter, instruction-memory address and IF/ID
// pipeline register. A taken branch from EX redirects fetch, squashes the
// wrong-path instruction into a bubble and bumps a saturating counter.
module pc_fetch_stage #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pcsrc,
    input  logic [ADDR_WIDTH-1:0]  branch_pc_plus4,
    input  logic [ADDR_WIDTH-1:0]  branch_offset,
    input  logic                   stall,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic [ADDR_WIDTH-1:0]  if_id_pc_plus4,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic                   if_id_valid,
    output logic                   flush,
    output logic [CNT_WIDTH-1:0]   taken_count
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

    logic [ADDR_WIDTH-1:0]  pc_reg, pc_next;
    logic [ADDR_WIDTH-1:0]  ifid_pc4_reg, ifid_pc4_next;
    logic [INSTR_WIDTH-1:0] ifid_instr_reg, ifid_instr_next;
    logic                   ifid_valid_reg, ifid_valid_next;
    logic                   flush_reg, flush_next;
    logic [CNT_WIDTH-1:0]   count_reg, count_next;

    logic [ADDR_WIDTH-1:0]  pc_plus4;
    logic [ADDR_WIDTH-1:0]  branch_target;
    logic                   count_full;

    // Sequential-address and branch-target adders; both wrap silently.
    always_comb begin
        pc_plus4      = pc_reg + PC_STEP;
        branch_target = branch_pc_plus4 + (branch_offset << 2);
        count_full    = &count_reg;
    end

    // Next-state selection: a taken branch beats a stall, a stall beats advance.
    always_comb begin
        pc_next         = pc_reg;
        ifid_pc4_next   = ifid_pc4_reg;
        ifid_instr_next = ifid_instr_reg;
        ifid_valid_next = ifid_valid_reg;
        flush_next      = 1'b0;
        count_next      = count_reg;
        if (pcsrc) begin
            // The instruction fetched this cycle is wrong-path: squash it.
            pc_next         = branch_target;
            ifid_pc4_next   = '0;
            ifid_instr_next = '0;
            ifid_valid_next = 1'b0;
            flush_next      = 1'b1;
            if (!count_full) begin
                count_next = count_reg + CNT_ONE;
            end
        end else if (!stall) begin
            pc_next         = pc_plus4;
            ifid_pc4_next   = pc_plus4;
            ifid_instr_next = instr_in;
            ifid_valid_next = 1'b1;
        end
    end

    // State registers with synchronous reset overriding everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg         <= RESET_PC;
            ifid_pc4_reg   <= '0;
            ifid_instr_reg <= '0;
            ifid_valid_reg <= 1'b0;
            flush_reg      <= 1'b0;
            count_reg      <= '0;
        end else begin
            pc_reg         <= pc_next;
            ifid_pc4_reg   <= ifid_pc4_next;
            ifid_instr_reg <= ifid_instr_next;
            ifid_valid_reg <= ifid_valid_next;
            flush_reg      <= flush_next;
            count_reg      <= count_next;
        end
    end

    assign pc_out         = pc_reg;
    assign if_id_pc_plus4 = ifid_pc4_reg;
    assign if_id_instr    = ifid_instr_reg;
    assign if_id_valid    = ifid_valid_reg;
    assign flush          = flush_reg;
    assign taken_count    = count_reg;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: directed vector table for the listed corner cases, then
// randomized traffic checked against a per-edge behavioural model.
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, pcsrc, stall;
    logic [31:0] branch_pc_plus4, branch_offset;
    logic [31:0] instr_in;
    logic [31:0] key;

    logic [31:0] pc_out, if_id_pc_plus4, if_id_instr;
    logic        if_id_valid, flush;
    logic [15:0] taken_count;

    logic [31:0] pc_out2, if_id_pc_plus4_2, if_id_instr2;
    logic        if_id_valid2, flush2;
    logic [1:0]  taken_count2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Instruction memory: word content is a function of its address.
    assign instr_in = (32'h11111111 + pc_out) ^ key;

    pc_fetch_stage dut (
        .clk(clk), .reset(reset), .pcsrc(pcsrc),
        .branch_pc_plus4(branch_pc_plus4), .branch_offset(branch_offset),
        .stall(stall), .instr_in(instr_in), .pc_out(pc_out),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid), .flush(flush), .taken_count(taken_count)
    );

    // Narrow-counter instance for the saturation check; shares all inputs.
    pc_fetch_stage #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .pcsrc(pcsrc),
        .branch_pc_plus4(branch_pc_plus4), .branch_offset(branch_offset),
        .stall(stall), .instr_in(instr_in), .pc_out(pc_out2),
        .if_id_pc_plus4(if_id_pc_plus4_2), .if_id_instr(if_id_instr2),
        .if_id_valid(if_id_valid2), .flush(flush2), .taken_count(taken_count2)
    );

    typedef struct {
        logic        rst, br, st;
        logic [31:0] bpc, off;
        logic [31:0] pc, ifpc, instr;
        logic        v, fl;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic br, input logic st,
                       input logic [31:0] bpc, input logic [31:0] off,
                       input logic [31:0] pc, input logic [31:0] ifpc,
                       input logic [31:0] instr, input logic v, input logic fl,
                       input logic [15:0] cnt, input logic [1:0] cnt2);
        vec_t e;
        e.rst = rst; e.br = br; e.st = st; e.bpc = bpc; e.off = off;
        e.pc = pc; e.ifpc = ifpc; e.instr = instr; e.v = v; e.fl = fl;
        e.cnt = cnt; e.cnt2 = cnt2;
        vecs.push_back(e);
    endtask

    task automatic check(input string nm, input int step,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, step, act, exp);
        end
    endtask

    task automatic check_all(input int step, input logic [31:0] pc,
                             input logic [31:0] ifpc, input logic [31:0] instr,
                             input logic v, input logic fl,
                             input logic [15:0] cnt, input logic [1:0] cnt2);
        check("pc_out", step, pc_out, pc);
        check("if_id_pc_plus4", step, if_id_pc_plus4, ifpc);
        check("if_id_instr", step, if_id_instr, instr);
        check("if_id_valid", step, {31'd0, if_id_valid}, {31'd0, v});
        check("flush", step, {31'd0, flush}, {31'd0, fl});
        check("taken_count", step, {16'd0, taken_count}, {16'd0, cnt});
        check("taken_count_w2", step, {30'd0, taken_count2}, {30'd0, cnt2});
        check("pc_out_w2", step, pc_out2, pc);
    endtask

    // Behavioural model state.
    logic [31:0] m_pc, m_ifpc, m_instr;
    logic        m_v, m_fl;
    int          m_cnt, m_cnt2;

    task automatic model_edge();
        if (reset) begin
            m_pc = 32'd0; m_ifpc = 0; m_instr = 0; m_v = 0; m_fl = 0;
            m_cnt = 0; m_cnt2 = 0;
        end else if (pcsrc) begin
            m_pc = branch_pc_plus4 + branch_offset * 32'd4;
            m_ifpc = 0; m_instr = 0; m_v = 0; m_fl = 1;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end else if (stall) begin
            m_fl = 0;
        end else begin
            m_instr = (32'h11111111 + m_pc) ^ key;
            m_pc = m_pc + 32'd4;
            m_ifpc = m_pc;
            m_v = 1; m_fl = 0;
        end
    endtask

    initial begin
        //   rst br st  bpc            off            pc             ifpc     instr          v  fl cnt c2
        add(1, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,   32'h0,         0, 0, 0, 0);
        add(0, 0, 0, 32'h0,         32'h0,         32'h4,         32'h4,   32'h11111111,  1, 0, 0, 0);
        add(0, 0, 0, 32'h0,         32'h0,         32'h8,         32'h8,   32'h11111115,  1, 0, 0, 0);
        add(0, 0, 0, 32'h0,         32'h0,         32'hC,         32'hC,   32'h11111119,  1, 0, 0, 0);
        add(0, 0, 0, 32'h0,         32'h0,         32'h10,        32'h10,  32'h1111111D,  1, 0, 0, 0);
        add(0, 1, 0, 32'h20,        32'hFFFFFFFE,  32'h18,        32'h0,   32'h0,         0, 1, 1, 1);
        add(0, 0, 0, 32'h0,         32'h0,         32'h1C,        32'h1C,  32'h11111129,  1, 0, 1, 1);
        add(0, 1, 0, 32'h3C,        32'h0,         32'h3C,        32'h0,   32'h0,         0, 1, 2, 2);
        add(0, 0, 0, 32'h0,         32'h0,         32'h40,        32'h40,  32'h1111114D,  1, 0, 2, 2);
        add(0, 0, 1, 32'h0,         32'h0,         32'h40,        32'h40,  32'h1111114D,  1, 0, 2, 2);
        add(0, 0, 1, 32'h0,         32'h0,         32'h40,        32'h40,  32'h1111114D,  1, 0, 2, 2);
        add(0, 0, 1, 32'h0,         32'h0,         32'h40,        32'h40,  32'h1111114D,  1, 0, 2, 2);
        add(0, 0, 0, 32'h0,         32'h0,         32'h44,        32'h44,  32'h11111151,  1, 0, 2, 2);
        add(0, 1, 1, 32'hF0,        32'h4,         32'h100,       32'h0,   32'h0,         0, 1, 3, 3);
        add(0, 0, 1, 32'h0,         32'h0,         32'h100,       32'h0,   32'h0,         0, 0, 3, 3);
        add(0, 1, 0, 32'hFFFFFFFC,  32'h2,         32'h4,         32'h0,   32'h0,         0, 1, 4, 3);
        add(0, 1, 0, 32'h100,       32'h1,         32'h104,       32'h0,   32'h0,         0, 1, 5, 3);
        add(1, 1, 1, 32'h200,       32'h8,         32'h0,         32'h0,   32'h0,         0, 0, 0, 0);
        add(0, 0, 0, 32'h0,         32'h0,         32'h4,         32'h4,   32'h11111111,  1, 0, 0, 0);

        key = 32'd0;
        reset = 1'b1; pcsrc = 1'b0; stall = 1'b0;
        branch_pc_plus4 = '0; branch_offset = '0;
        @(negedge clk);

        foreach (vecs[i]) begin
            reset = vecs[i].rst; pcsrc = vecs[i].br; stall = vecs[i].st;
            branch_pc_plus4 = vecs[i].bpc; branch_offset = vecs[i].off;
            @(posedge clk);
            #1;
            $display("vec %0d: rst=%0b br=%0b st=%0b pc=%h ifpc=%h instr=%h v=%0b fl=%0b cnt=%0d",
                     i, vecs[i].rst, vecs[i].br, vecs[i].st, pc_out, if_id_pc_plus4,
                     if_id_instr, if_id_valid, flush, taken_count);
            check_all(i, vecs[i].pc, vecs[i].ifpc, vecs[i].instr, vecs[i].v,
                      vecs[i].fl, vecs[i].cnt, vecs[i].cnt2);
        end

        // Randomized phase against the model.
        key = $urandom();
        for (int c = 0; c < 1000; c++) begin
            reset = (c == 0) || ($urandom_range(0, 63) == 0);
            pcsrc = ($urandom_range(0, 4) == 0);
            stall = ($urandom_range(0, 3) == 0);
            branch_pc_plus4 = $urandom() & 32'hFFFFFFFC;
            if ($urandom_range(0, 1) == 0)
                branch_offset = 32'($urandom_range(0, 64)) - 32'd32;
            else
                branch_offset = $urandom();
            @(posedge clk);
            model_edge();
            #1;
            $display("rnd %0d: rst=%0b br=%0b st=%0b pc=%h ifpc=%h instr=%h v=%0b fl=%0b cnt=%0d",
                     c, reset, pcsrc, stall, pc_out, if_id_pc_plus4, if_id_instr,
                     if_id_valid, flush, taken_count);
            check_all(1000 + c, m_pc, m_ifpc, m_instr, m_v, m_fl,
                      16'(m_cnt), 2'(m_cnt2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Program-counter and instruction-fetch stage of the pipelined datapath.
- Holds the PC, drives the instruction-memory address, and registers the fetched instruction into the IF/ID pipeline register.
- Consumes the taken-branch decision pcsrc, the branch & zero result from the EX stage, and redirects fetch to the branch target.
- On a taken branch, squashes the wrong-path instruction and counts taken branches for performance debug.

Parameters:
- ADDR_WIDTH, 32, width of PC, addresses and offsets.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.
- CNT_WIDTH, 16, width of the saturating taken-branch counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- pcsrc  input  1  taken-branch decision (branch & zero) from EX.
- branch_pc_plus4  input  ADDR_WIDTH  PC+4 of the branch instruction currently in EX.
- branch_offset  input  ADDR_WIDTH  sign-extended immediate, in words.
- stall  input  1  hazard-unit hold request.
- instr_in  input  INSTR_WIDTH  instruction-memory read data for address pc_out; combinational, same cycle.
- pc_out  output  ADDR_WIDTH  current PC, drives the instruction-memory address.
- if_id_pc_plus4  output  ADDR_WIDTH  registered PC+4 of the instruction in ID.
- if_id_instr  output  INSTR_WIDTH  registered instruction in ID.
- if_id_valid  output  1  1 = if_id_instr is a real instruction; 0 = bubble.
- flush  output  1  registered; 1 for the cycle after a taken branch was accepted.
- taken_count  output  CNT_WIDTH  number of taken branches since reset.

Behaviour:
- All state updates on the rising edge of clk. Priority per edge: reset > pcsrc > stall > normal advance.
- Reset values (reset high at the edge, even mid-branch or mid-stall):
  - pc_out = RESET_PC
  - if_id_pc_plus4 = 0, if_id_instr = 0, if_id_valid = 0
  - flush = 0, taken_count = 0
- Arithmetic:
  - pc_plus4 = pc_out + 4.
  - target = branch_pc_plus4 + (branch_offset << 2).
  - Both truncated to ADDR_WIDTH; wrap-around modulo 2^ADDR_WIDTH, no overflow flag.
- pcsrc = 1 (stall ignored):
  - pc_out <= target.
  - if_id_instr <= 0 (NOP), if_id_valid <= 0, if_id_pc_plus4 <= 0.
  - flush <= 1.
  - taken_count <= taken_count + 1, saturating at all-ones.
- pcsrc = 0, stall = 1:
  - pc_out and all IF/ID registers hold.
  - flush <= 0; taken_count holds.
- pcsrc = 0, stall = 0:
  - pc_out <= pc_plus4.
  - if_id_instr <= instr_in, if_id_pc_plus4 <= pc_plus4, if_id_valid <= 1.
  - flush <= 0.
- Latency:
  - Instruction at address A appears on if_id_instr one edge after pc_out = A with no stall.
  - Branch redirect takes effect one edge after pcsrc is sampled high; the target instruction reaches IF/ID on the following edge.
- Back-to-back pcsrc cycles: each redirects to its own target, each inserts a bubble, and each increments the counter.
- First cycle after reset release: pc_out = RESET_PC, if_id_valid = 0.
- pcsrc and reset both high: reset wins; the counter stays 0.
- No X propagation: every output is driven from a register.

Test Plan:
- Reset, then 4 cycles with no stall and instr_in = 0x11111111 + pc_out:
  - pc_out steps 0, 4, 8, 12, 16.
  - if_id_instr lags one cycle, if_id_pc_plus4 = pc_out.
  - if_id_valid = 1 from the second edge.
- pcsrc = 1, branch_pc_plus4 = 0x20, branch_offset = 0xFFFFFFFE:
  - next pc_out = 0x18, if_id_valid = 0, if_id_instr = 0, flush = 1, taken_count = 1.
  - flush returns to 0 the cycle after.
- stall = 1 for 3 cycles with pc_out = 0x40: pc_out stays 0x40 and the IF/ID registers hold; resumes at 0x44 on release.
- pcsrc = 1 and stall = 1 together, target 0x100: pc_out = 0x100 and a bubble is inserted (branch overrides stall).
- Wrap and saturation:
  - branch_pc_plus4 = 0xFFFFFFFC, offset = 2: pc_out = 0x00000004.
  - CNT_WIDTH = 2 with 5 taken branches: taken_count sticks at 3.
- reset asserted during a stall and coincident with pcsrc:
  - next edge gives pc_out = RESET_PC, if_id_valid = 0, flush = 0, taken_count = 0.
